// File: rtl/ram16k_arb_pkg.sv
// ============================================================================
// Module   : ram16k_arb_pkg
// Purpose  : Shared widths, owner encoding and command record for the
//            16K x 16 data RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram16k_arb_pkg;

  localparam int DEF_ADDR_W = 14;
  localparam int DEF_DATA_W = 16;

  typedef enum logic {
    OWNER_CPU  = 1'b0,
    OWNER_SCAN = 1'b1
  } owner_e;

  typedef struct packed {
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
    owner_e                owner;
  } cmd_t;

endpackage

`default_nettype wire

// File: rtl/ram16k_arbiter_if.sv
// ============================================================================
// Module   : ram16k_arbiter_if
// Purpose  : One requester's command/response channel into the RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram16k_arbiter_if
  import ram16k_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

`default_nettype wire

// File: rtl/ram16k_arb_pick.sv
// ============================================================================
// Module   : ram16k_arb_pick
// Purpose  : Grant selection between the two requesters. Fixed priority
//            (requester 0 first) unless RAM16K_ARB_ROUND_ROBIN_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram16k_arb_pick (
`ifdef RAM16K_ARB_ROUND_ROBIN_EN
  input  logic clk,
`endif
  input  logic rst_n,
  input  logic valid_0,
  input  logic valid_1,
  output logic grant_0,
  output logic grant_1
);

`ifdef RAM16K_ARB_ROUND_ROBIN_EN
  // 1 = requester 1 was granted last, so requester 0 wins the next tie
  logic r_last_grant;

  always_comb begin
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    if (rst_n) begin
      if (valid_0 && valid_1) begin
        grant_0 = r_last_grant;
        grant_1 = ~r_last_grant;
      end else begin
        grant_0 = valid_0;
        grant_1 = valid_1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (grant_0 || grant_1) begin
      r_last_grant <= grant_1;
    end
  end
`else
  always_comb begin
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    if (rst_n) begin
      grant_0 = valid_0;
      grant_1 = valid_1 & ~valid_0;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/ram16k_arbiter.sv
// ============================================================================
// Module   : ram16k_arbiter
// Purpose  : Shares the single RAM port between CPU (0) and scanner (1);
//            command stage drives the RAM, response stage routes read data.
//            Optional macro: RAM16K_ARB_ROUND_ROBIN_EN selects round-robin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram16k_arbiter
  import ram16k_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram16k_arbiter_if.slave       port_0,
  ram16k_arbiter_if.slave       port_1,
  output logic                  ram_load,
  output logic [ADDR_W-1:0]     ram_address,
  output logic [DATA_W-1:0]     ram_in_value,
  input  logic [DATA_W-1:0]     ram_out
);

  logic              w_grant_0;
  logic              w_grant_1;

  logic              w_next_valid;
  owner_e            w_next_owner;
  logic              w_next_write;
  logic [ADDR_W-1:0] w_next_addr;
  logic [DATA_W-1:0] w_next_wdata;

  logic              r_cmd_valid;
  owner_e            r_cmd_owner;
  logic              r_cmd_write;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic [DATA_W-1:0] r_cmd_wdata;

  logic              r_rsp_pending;
  owner_e            r_rsp_owner;
  logic              r_rsp_write;

  logic              w_rsp_hit_0;
  logic              w_rsp_hit_1;

  ram16k_arb_pick u_pick (
`ifdef RAM16K_ARB_ROUND_ROBIN_EN
    .clk     (clk),
`endif
    .rst_n   (rst_n),
    .valid_0 (port_0.req_valid),
    .valid_1 (port_1.req_valid),
    .grant_0 (w_grant_0),
    .grant_1 (w_grant_1)
  );

  assign port_0.req_ready = w_grant_0;
  assign port_1.req_ready = w_grant_1;

  // Stage C loads the winner's command; with no handshake every field clears
  always_comb begin
    w_next_valid = w_grant_0 | w_grant_1;
    w_next_owner = OWNER_CPU;
    w_next_write = 1'b0;
    w_next_addr  = '0;
    w_next_wdata = '0;
    if (w_grant_1) begin
      w_next_owner = OWNER_SCAN;
      w_next_write = port_1.req_write;
      w_next_addr  = port_1.req_addr;
      w_next_wdata = port_1.req_wdata;
    end else if (w_grant_0) begin
      w_next_write = port_0.req_write;
      w_next_addr  = port_0.req_addr;
      w_next_wdata = port_0.req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_valid <= 1'b0;
      r_cmd_owner <= OWNER_CPU;
      r_cmd_write <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
    end else begin
      r_cmd_valid <= w_next_valid;
      r_cmd_owner <= w_next_owner;
      r_cmd_write <= w_next_write;
      r_cmd_addr  <= w_next_addr;
      r_cmd_wdata <= w_next_wdata;
    end
  end

  // Stage R tracks whose command the RAM executed on the last edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_pending <= 1'b0;
      r_rsp_owner   <= OWNER_CPU;
      r_rsp_write   <= 1'b0;
    end else begin
      r_rsp_pending <= r_cmd_valid;
      r_rsp_owner   <= r_cmd_owner;
      r_rsp_write   <= r_cmd_write;
    end
  end

  assign ram_load     = r_cmd_valid & r_cmd_write;
  assign ram_address  = r_cmd_addr;
  assign ram_in_value = r_cmd_wdata;

  assign w_rsp_hit_0 = r_rsp_pending && (r_rsp_owner == OWNER_CPU);
  assign w_rsp_hit_1 = r_rsp_pending && (r_rsp_owner == OWNER_SCAN);

  assign port_0.rsp_valid = w_rsp_hit_0;
  assign port_1.rsp_valid = w_rsp_hit_1;
  // Write acks carry zero: the RAM read register holds stale data on writes
  assign port_0.rsp_rdata = (w_rsp_hit_0 && !r_rsp_write) ? ram_out : '0;
  assign port_1.rsp_rdata = (w_rsp_hit_1 && !r_rsp_write) ? ram_out : '0;

endmodule

`default_nettype wire

// File: tb/tb_ram16k_arbiter.sv
// ============================================================================
// Module   : tb_ram16k_arbiter
// Purpose  : Scoreboard bench for ram16k_arbiter with a behavioural RAM and
//            a word-array reference model updated in grant order.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram16k_arbiter;
  import ram16k_arb_pkg::*;

  localparam int AW = 14;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram16k_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) port_0 ();
  ram16k_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) port_1 ();

  logic          ram_load;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_in_value;
  logic [DW-1:0] ram_out = '0;

  ram16k_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .port_0       (port_0),
    .port_1       (port_1),
    .ram_load     (ram_load),
    .ram_address  (ram_address),
    .ram_in_value (ram_in_value),
    .ram_out      (ram_out)
  );

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 14'h3FFF) return 16'h1234;
    return {2'b01, a} ^ 16'hA5C3;
  endfunction

  // Behavioural RAM: registered read, read register untouched on writes
  logic [DW-1:0] mem    [0:16383];
  bit            mem_wr [0:16383];
  always @(posedge clk) begin
    if (ram_load) begin
      mem[ram_address]    <= ram_in_value;
      mem_wr[ram_address] <= 1'b1;
    end else begin
      ram_out <= mem_wr[ram_address] ? mem[ram_address] : init_val(ram_address);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            due;
    logic [DW-1:0] rdata;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  logic [DW-1:0] model_mem [0:16383];
  bit            model_last = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int who, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.due = cyc + 2;
    if (w) begin
      model_mem[a] = d;
      e.rdata = '0;
    end else begin
      e.rdata = model_mem[a];
    end
    if (who == 0) q0.push_back(e);
    else          q1.push_back(e);
  endtask

  // One cycle of stimulus; grants are predicted from the arbitration rule
  task automatic step(input bit v0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input bit v1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      output bit g0, output bit g1);
    bit e0, e1;
    @(negedge clk);
    port_0.req_valid = v0; port_0.req_write = w0; port_0.req_addr = a0; port_0.req_wdata = d0;
    port_1.req_valid = v1; port_1.req_write = w1; port_1.req_addr = a1; port_1.req_wdata = d1;
    #1;
`ifdef RAM16K_ARB_ROUND_ROBIN_EN
    if (v0 && v1) begin
      e0 = model_last;
      e1 = !model_last;
    end else begin
      e0 = v0;
      e1 = v1;
    end
`else
    e0 = v0;
    e1 = v1 && !v0;
`endif
    check("req_ready_0", {31'd0, port_0.req_ready}, {31'd0, e0});
    check("req_ready_1", {31'd0, port_1.req_ready}, {31'd0, e1});
    g0 = port_0.req_ready && v0;
    g1 = port_1.req_ready && v1;
    if (g0) push(0, w0, a0, d0);
    if (g1) push(1, w1, a1, d1);
    if (g0 || g1) model_last = g1;
  endtask

  task automatic idle(input int n);
    bit g0, g1;
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, '0, g0, g1);
  endtask

  task automatic mon(input int who, input bit v, input logic [DW-1:0] rd);
    exp_t e;
    int   sz;
    sz = (who == 0) ? q0.size() : q1.size();
    if (sz > 0) begin
      if (who == 0) e = q0[0];
      else          e = q1[0];
    end
    if (v) begin
      if (sz == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_%0d_unexpected: got response rdata %h at cycle %0d, expected none", who, rd, cyc);
      end else begin
        if (who == 0) void'(q0.pop_front());
        else          void'(q1.pop_front());
        check($sformatf("rsp_%0d_cycle", who), cyc, e.due);
        check($sformatf("rsp_%0d_rdata", who), {16'd0, rd}, {16'd0, e.rdata});
      end
    end else begin
      check($sformatf("rsp_%0d_idle_rdata", who), {16'd0, rd}, 32'd0);
      if (sz > 0 && e.due <= cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_%0d_missing: got no response at cycle %0d, expected one due at %0d", who, cyc, e.due);
        if (who == 0) void'(q0.pop_front());
        else          void'(q1.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, port_0.rsp_valid, port_0.rsp_rdata);
      mon(1, port_1.rsp_valid, port_1.rsp_rdata);
    end
  end

  task automatic gen(output bit v, output bit w, output logic [AW-1:0] a, output logic [DW-1:0] d);
    v = ($urandom_range(0, 3) != 0);
    w = ($urandom_range(0, 1) == 1);
    a = ($urandom_range(0, 15) == 0) ? 14'h3FFF : 14'h0100 + 14'($urandom_range(0, 7));
    d = 16'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ram_load"},     {31'd0, ram_load}, 32'd0);
    check({tag, "_ram_address"},  {18'd0, ram_address}, 32'd0);
    check({tag, "_ram_in_value"}, {16'd0, ram_in_value}, 32'd0);
    check({tag, "_rsp_valid_0"},  {31'd0, port_0.rsp_valid}, 32'd0);
    check({tag, "_rsp_valid_1"},  {31'd0, port_1.rsp_valid}, 32'd0);
    check({tag, "_rsp_rdata_0"},  {16'd0, port_0.rsp_rdata}, 32'd0);
    check({tag, "_rsp_rdata_1"},  {16'd0, port_1.rsp_rdata}, 32'd0);
    check({tag, "_req_ready_0"},  {31'd0, port_0.req_ready}, 32'd0);
    check({tag, "_req_ready_1"},  {31'd0, port_1.req_ready}, 32'd0);
  endtask

  bit            g0, g1;
  bit            hv0, hw0, hv1, hw1;
  logic [AW-1:0] ha0, ha1;
  logic [DW-1:0] hd0, hd1;
  logic [DW-1:0] prior;

  initial begin
    for (int i = 0; i < 16384; i++) model_mem[i] = init_val(14'(i));
    port_0.req_valid = 1'b1; port_0.req_write = 1'b0; port_0.req_addr = '0; port_0.req_wdata = '0;
    port_1.req_valid = 1'b1; port_1.req_write = 1'b0; port_1.req_addr = '0; port_1.req_wdata = '0;

    // Reset values with both requesters asserting valid
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    port_0.req_valid = 1'b0;
    port_1.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Write then read the same word on consecutive cycles
    step(1, 1, 14'h0100, 16'hBEEF, 0, 0, '0, '0, g0, g1);
    step(1, 0, 14'h0100, '0,       0, 0, '0, '0, g0, g1);
    idle(3);

    // Scanner alone reads a preloaded word
    step(0, 0, '0, '0, 1, 0, 14'h3FFF, '0, g0, g1);
    idle(3);

    // Both requesters valid every cycle
    ha0 = 14'h0001;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, ha0, '0, 1, 0, 14'h3FFF, '0, g0, g1);
      if (g0) ha0 = ha0 + 14'd1;
    end
    idle(3);

    // Reset one cycle after a write handshake: the write must be dropped
    prior = model_mem[14'h0200];
    step(1, 1, 14'h0200, 16'hDEAD, 0, 0, '0, '0, g0, g1);
    @(negedge clk);
    port_0.req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    model_mem[14'h0200] = prior;
    model_last = 1'b1;
    #1;
    port_0.req_valid = 1'b1;
    port_1.req_valid = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    #1;
    check("midreset_hold_ram_load", {31'd0, ram_load}, 32'd0);
    port_0.req_valid = 1'b0;
    port_1.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 14'h0200, '0, 0, 0, '0, '0, g0, g1);
    idle(3);

    // Randomized traffic; a requester holds its command until granted
    gen(hv0, hw0, ha0, hd0);
    gen(hv1, hw1, ha1, hd1);
    for (int i = 0; i < 400; i++) begin
      step(hv0, hw0, ha0, hd0, hv1, hw1, ha1, hd1, g0, g1);
      if (g0 || !hv0) gen(hv0, hw0, ha0, hd0);
      if (g1 || !hv1) gen(hv1, hw1, ha1, hd1);
    end
    idle(5);

    check("drain_q0", q0.size(), 32'd0);
    check("drain_q1", q1.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
